// File: rtl/adder_test_pkg.sv
// Shared types and helpers for the adder self-check engine.
package adder_test_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} chk_state_t;

  localparam int unsigned ERRCNT_W = 16;
  // Widest adder the golden helper supports; callers keep WIDTH below this.
  localparam int unsigned GOLD_W   = 16;

  function automatic int unsigned vec_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic logic [GOLD_W:0] golden_sum(input logic [GOLD_W-1:0] a,
                                                 input logic [GOLD_W-1:0] b,
                                                 input logic              cin);
    return {1'b0, a} + {1'b0, b} + {{GOLD_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth delay line with a clearable valid bit; depth 0 is a wire.
module pipe_delay #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned DW    = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clock, reset, clear};
    assign out_valid  = in_valid;
    assign out_data   = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q <= '0;
      end else if (clear) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int unsigned i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // Payload needs no reset: it is only consumed alongside a set valid bit.
    always_ff @(posedge clock) begin
      data_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/adder4_checker.sv
// Exhaustive on-chip stimulus and checker for an adder under test.
module adder4_checker
  import adder_test_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned PIPE_LAT     = 0,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  output logic [WIDTH-1:0]       io_A,
  output logic [WIDTH-1:0]       io_B,
  output logic                   io_Cin,
  input  logic [WIDTH-1:0]       io_Sum,
  input  logic                   io_Cout,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_pass,
  output logic [ERRCNT_W-1:0]    io_errCount,
  output logic [2*WIDTH:0]       io_failVec,
  output logic [WIDTH:0]         io_failResult
);

  localparam int unsigned VW    = vec_w(WIDTH);
  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned DW    = RW + VW;
  localparam int unsigned DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  chk_state_t state, state_nxt;

  logic [VW-1:0]       vec;
  logic [DRN_W-1:0]    drain_cnt;
  logic [ERRCNT_W-1:0] err_cnt;
  logic [VW-1:0]       fail_vec;
  logic [RW-1:0]       fail_res;

  logic [GOLD_W-1:0]   a_ext, b_ext;
  logic [GOLD_W:0]     gold_full;
  logic [RW-1:0]       exp_now;
  logic                unused_gold;

  logic                q_valid;
  logic [DW-1:0]       q_data;
  logic [RW-1:0]       q_exp;
  logic [VW-1:0]       q_vec;
  logic [RW-1:0]       dut_res;

  logic start_sweep, last_vec, drain_last, chk_en, mismatch, stop;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = vec[WIDTH-1:0];
    b_ext[WIDTH-1:0] = vec[2*WIDTH-1:WIDTH];
    gold_full   = golden_sum(a_ext, b_ext, vec[VW-1]);
    exp_now     = gold_full[RW-1:0];
    unused_gold = ^gold_full[GOLD_W:RW];
  end

  pipe_delay #(.DEPTH(PIPE_LAT), .DW(DW)) u_delay (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_sweep | stop),
    .in_valid  (state == DRIVE),
    .in_data   ({exp_now, vec}),
    .out_valid (q_valid),
    .out_data  (q_data)
  );

  assign q_exp   = q_data[DW-1:VW];
  assign q_vec   = q_data[VW-1:0];
  assign dut_res = {io_Cout, io_Sum};

  assign start_sweep = io_start && (state == IDLE || state == DONE);
  assign last_vec    = &vec;
  assign drain_last  = (drain_cnt == DRN_W'(PIPE_LAT - 1));
  // DRAIN repeats enter the delay line with valid low, so they never reach the compare.
  assign chk_en      = q_valid && (state == DRIVE || state == DRAIN);
  assign mismatch    = chk_en && (q_exp != dut_res);
  assign stop        = mismatch && STOP_ON_FAIL;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (io_start) state_nxt = DRIVE;
      DRIVE: begin
        if (stop)          state_nxt = DONE;
        else if (last_vec) state_nxt = (PIPE_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN:      if (stop || drain_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vec       <= '0;
      drain_cnt <= '0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_res  <= '0;
    end else if (start_sweep) begin
      vec       <= '0;
      drain_cnt <= '0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_res  <= '0;
    end else begin
      if (state == DRIVE && !last_vec && !stop) vec <= vec + VW'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRN_W'(1) : '0;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
        if (err_cnt == '0) begin
          fail_vec <= q_vec;
          fail_res <= dut_res;
        end
      end
    end
  end

  assign io_A          = vec[WIDTH-1:0];
  assign io_B          = vec[2*WIDTH-1:WIDTH];
  assign io_Cin        = vec[VW-1];
  assign io_busy       = (state == DRIVE) || (state == DRAIN);
  assign io_done       = (state == DONE);
  assign io_pass       = (state == DONE) && (err_cnt == '0);
  assign io_errCount   = err_cnt;
  assign io_failVec    = fail_vec;
  assign io_failResult = fail_res;

endmodule

// File: tb/tb_adder4_checker.sv
// Bench: three checker configurations driving fault-injectable adder models.
module tb_adder4_checker;

  localparam int NV = 512;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode  = 0;
  logic [4:0] fmask [NV];

  logic [3:0]  a_s [3], b_s [3], sum_s [3];
  logic        cin_s [3], cout_s [3], busy_s [3], done_s [3], pass_s [3];
  logic [15:0] err_s [3];
  logic [8:0]  fv_s [3];
  logic [4:0]  fr_s [3];
  logic [4:0]  res_c [3];
  logic [4:0]  r1, r2;

  int vectors = 0, miscompares = 0;
  int done_at [3];
  int snap_err [3], snap_busy [3], snap_fv [3];

  typedef struct {
    int mode; int inst; int err; int fv; int fr; int done_at;
  } vec_t;
  vec_t tbl [9];

  always #5 clock = ~clock;

  // Adder under test: correct sum with an optional injected fault.
  function automatic logic [4:0] dut_res(input logic [8:0] v, input int m, input logic [4:0] mask);
    logic [4:0] good;
    good = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
    case (m)
      1:       return good & 5'h1E;
      2:       return good ^ 5'h10;
      3:       return good ^ mask;
      default: return good;
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign res_c[k] = dut_res({cin_s[k], b_s[k], a_s[k]}, mode, fmask[{cin_s[k], b_s[k], a_s[k]}]);
  end
  assign {cout_s[0], sum_s[0]} = res_c[0];
  assign {cout_s[1], sum_s[1]} = res_c[1];
  assign {cout_s[2], sum_s[2]} = r2;
  always @(posedge clock) begin
    r1 <= res_c[2];
    r2 <= r1;
  end

  adder4_checker #(.WIDTH(4), .PIPE_LAT(0), .STOP_ON_FAIL(1'b0)) u_sweep (
    .clock(clock), .reset(rst_n), .io_start(start),
    .io_A(a_s[0]), .io_B(b_s[0]), .io_Cin(cin_s[0]), .io_Sum(sum_s[0]), .io_Cout(cout_s[0]),
    .io_busy(busy_s[0]), .io_done(done_s[0]), .io_pass(pass_s[0]), .io_errCount(err_s[0]),
    .io_failVec(fv_s[0]), .io_failResult(fr_s[0]));

  adder4_checker #(.WIDTH(4), .PIPE_LAT(0), .STOP_ON_FAIL(1'b1)) u_stop (
    .clock(clock), .reset(rst_n), .io_start(start),
    .io_A(a_s[1]), .io_B(b_s[1]), .io_Cin(cin_s[1]), .io_Sum(sum_s[1]), .io_Cout(cout_s[1]),
    .io_busy(busy_s[1]), .io_done(done_s[1]), .io_pass(pass_s[1]), .io_errCount(err_s[1]),
    .io_failVec(fv_s[1]), .io_failResult(fr_s[1]));

  adder4_checker #(.WIDTH(4), .PIPE_LAT(2), .STOP_ON_FAIL(1'b0)) u_pipe (
    .clock(clock), .reset(rst_n), .io_start(start),
    .io_A(a_s[2]), .io_B(b_s[2]), .io_Cin(cin_s[2]), .io_Sum(sum_s[2]), .io_Cout(cout_s[2]),
    .io_busy(busy_s[2]), .io_done(done_s[2]), .io_pass(pass_s[2]), .io_errCount(err_s[2]),
    .io_failVec(fv_s[2]), .io_failResult(fr_s[2]));

  task automatic check(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[u%0d]: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Reference: walk every vector in order, apply the sweep/stop rules arithmetically.
  task automatic model(input int m, input int lat, input bit stop_mode,
                       output int err, output int fv, output int fr, output int dn);
    err = 0; fv = 0; fr = 0; dn = NV + lat;
    for (int v = 0; v < NV; v++) begin
      int a, b, c, good;
      logic [4:0] got;
      a = v % 16; b = (v / 16) % 16; c = v / 256;
      good = a + b + c;
      got = dut_res(9'(v), m, fmask[v]);
      if (int'(got) != good) begin
        if (err == 0) begin
          fv = v;
          fr = int'(got);
        end
        err++;
        if (stop_mode) begin
          dn = v + 1 + lat;
          break;
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input int err, input int fv, input int fr, input int dn);
    check("errCount", k, int'(err_s[k]), err);
    check("failVec", k, int'(fv_s[k]), fv);
    check("failResult", k, int'(fr_s[k]), fr);
    check("pass", k, int'(pass_s[k]), (err == 0) ? 1 : 0);
    check("done_edge", k, done_at[k], dn);
  endtask

  task automatic check_reset(input int k);
    check("reset_vec", k, int'({cin_s[k], b_s[k], a_s[k]}), 0);
    check("reset_flags", k, int'({busy_s[k], done_s[k], pass_s[k]}), 0);
    check("reset_err", k, int'(err_s[k]), 0);
    check("reset_failVec", k, int'(fv_s[k]), 0);
    check("reset_failResult", k, int'(fr_s[k]), 0);
  endtask

  // Pulse start for edge E0, then count edges until each instance shows done.
  task automatic run_sweep(input int inject_at);
    for (int k = 0; k < 3; k++) done_at[k] = -1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      snap_err[k]  = int'(err_s[k]);
      snap_busy[k] = int'(busy_s[k]);
      snap_fv[k]   = int'(fv_s[k]);
    end
    for (int n = 1; n <= 700; n++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) if (done_s[k] && done_at[k] < 0) done_at[k] = n;
      start = (n == inject_at);
      if (done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int err, fv, fr, dn;
    int lat [3];
    bit stp [3];
    lat = '{0, 0, 2};
    stp = '{1'b0, 1'b1, 1'b0};

    tbl[0] = '{0, 0,   0, 9'h000, 5'h00, 512};
    tbl[1] = '{0, 1,   0, 9'h000, 5'h00, 512};
    tbl[2] = '{0, 2,   0, 9'h000, 5'h00, 514};
    tbl[3] = '{1, 0, 256, 9'h001, 5'h00, 512};
    tbl[4] = '{1, 1,   1, 9'h001, 5'h00,   2};
    tbl[5] = '{1, 2, 256, 9'h001, 5'h00, 514};
    tbl[6] = '{2, 0, 512, 9'h000, 5'h10, 512};
    tbl[7] = '{2, 1,   1, 9'h000, 5'h10,   1};
    tbl[8] = '{2, 2, 512, 9'h000, 5'h10, 514};

    for (int v = 0; v < NV; v++) fmask[v] = 5'h00;

    #12;
    for (int k = 0; k < 3; k++) check_reset(k);
    @(negedge clock);
    rst_n = 1'b1;

    for (int m = 0; m < 3; m++) begin
      mode = m;
      run_sweep(0);
      for (int k = 0; k < 3; k++) begin
        vec_t r;
        r = tbl[3*m + k];
        check_inst(r.inst, r.err, r.fv, r.fr, r.done_at);
      end
    end

    for (int it = 0; it < 4; it++) begin
      int dens;
      dens = (it == 0) ? 3 : 63;
      for (int v = 0; v < NV; v++)
        fmask[v] = ($urandom_range(0, dens) == 0) ? 5'($urandom_range(1, 31)) : 5'h00;
      mode = 3;
      run_sweep(0);
      for (int k = 0; k < 3; k++) begin
        model(3, lat[k], stp[k], err, fv, fr, dn);
        check_inst(k, err, fv, fr, dn);
      end
    end

    // Reset partway through a sweep.
    mode = 1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (int'({cin_s[0], b_s[0], a_s[0]}) == 100) break;
      @(posedge clock);
      #1;
    end
    check("reach_vec100", 0, int'({cin_s[0], b_s[0], a_s[0]}), 100);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_reset(k);
    @(negedge clock);
    rst_n = 1'b1;

    // Fresh sweep with a start pulse while busy: must not restart the sweep.
    run_sweep(200);
    model(1, 0, 1'b0, err, fv, fr, dn);
    check_inst(0, err, fv, fr, dn);
    model(1, 2, 1'b0, err, fv, fr, dn);
    check_inst(2, err, fv, fr, dn);

    // Start from DONE clears prior results and repeats the sweep.
    mode = 0;
    run_sweep(0);
    for (int k = 0; k < 3; k += 2) begin
      check("restart_err_cleared", k, snap_err[k], 0);
      check("restart_failVec_cleared", k, snap_fv[k], 0);
      check("restart_busy", k, snap_busy[k], 1);
      check_inst(k, tbl[k].err, tbl[k].fv, tbl[k].fr, tbl[k].done_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
